// File: rtl/decode_module.sv
// -----------------------------------------------------------------------------
// decode_module: instruction-decode stage of a 5-stage MIPS pipeline.
//
// Holds the 32-entry register file (with write-through bypass from writeback).
// Decodes control. Resolves beq/bne/j in ID and returns redirect, flush and
// stall controls to fetch. Detects load-use and branch-operand hazards. Registers
// the ID/EX pipeline state consumed by execute.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_if_id_pc/_instr     IF/ID pc (already pc+4) and instruction
//   i_wb_we/_addr/_data   writeback register-file write port
//   i_ex_mem_reg_write/_rd  EX/MEM producer, used for branch-operand hazards
//   o_brq_addr, o_jmp_addr  redirect targets returned to fetch
//   o_ctr_beq/_jmp/_flush   redirect and flush controls
//   o_pc_we, o_if_id_we     stall controls (0 = hold)
//   o_id_ex_*               registered ID/EX state
//                           o_id_ex_ctrl = {reg_write, mem_read, mem_write,
//                                           mem_to_reg, reg_dst, alu_src}
// -----------------------------------------------------------------------------
module decode_module #(
    parameter int NB_BITS = 32,
    parameter int NB_JMP  = 26,
    parameter int NB_REG  = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_if_id_pc,
    input  logic [NB_BITS-1:0] i_if_id_instr,
    input  logic               i_wb_we,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_BITS-1:0] i_wb_data,
    input  logic               i_ex_mem_reg_write,
    input  logic [NB_REG-1:0]  i_ex_mem_rd,
    output logic [NB_BITS-1:0] o_brq_addr,
    output logic [NB_JMP-1:0]  o_jmp_addr,
    output logic               o_ctr_beq,
    output logic               o_ctr_jmp,
    output logic               o_ctr_flush,
    output logic               o_pc_we,
    output logic               o_if_id_we,
    output logic [NB_BITS-1:0] o_id_ex_pc,
    output logic [NB_BITS-1:0] o_id_ex_rs_data,
    output logic [NB_BITS-1:0] o_id_ex_rt_data,
    output logic [NB_BITS-1:0] o_id_ex_imm,
    output logic [NB_REG-1:0]  o_id_ex_rs,
    output logic [NB_REG-1:0]  o_id_ex_rt,
    output logic [NB_REG-1:0]  o_id_ex_rd,
    output logic [5:0]         o_id_ex_op,
    output logic [5:0]         o_id_ex_funct,
    output logic [5:0]         o_id_ex_ctrl
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic signed [NB_BITS-1:0] sext16(input logic [15:0] v);
        return NB_BITS'($signed(v));
    endfunction

    // Instruction fields
    logic [5:0]        op, funct;
    logic [NB_REG-1:0] rs, rt, rd;
    logic [15:0]       imm16;

    assign op    = i_if_id_instr[31:26];
    assign rs    = i_if_id_instr[25:21];
    assign rt    = i_if_id_instr[20:16];
    assign rd    = i_if_id_instr[15:11];
    assign imm16 = i_if_id_instr[15:0];
    assign funct = i_if_id_instr[5:0];

    logic [NB_BITS-1:0] regs_q [2**NB_REG];

    logic [NB_BITS-1:0] id_ex_pc_q, id_ex_rs_data_q, id_ex_rt_data_q, id_ex_imm_q;
    logic [NB_REG-1:0]  id_ex_rs_q, id_ex_rt_q, id_ex_rd_q;
    logic [5:0]         id_ex_op_q, id_ex_funct_q, id_ex_ctrl_q, id_ex_ctrl_d;

    // Register-file read with same-cycle writeback bypass; $0 is hardwired to 0
    logic [NB_BITS-1:0] rs_data, rt_data;
    always_comb begin
        rs_data = regs_q[rs];
        if (rs == '0)
            rs_data = '0;
        else if (i_wb_we && i_wb_addr == rs)
            rs_data = i_wb_data;

        rt_data = regs_q[rt];
        if (rt == '0)
            rt_data = '0;
        else if (i_wb_we && i_wb_addr == rt)
            rt_data = i_wb_data;
    end

    // Control decode
    logic [5:0] ctrl_dec;
    logic       rt_is_src, is_beq, is_bne, is_j, zero_ext;
    always_comb begin
        ctrl_dec  = 6'b000000;
        rt_is_src = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        zero_ext  = 1'b0;
        case (op)
            // The all-zero word is the canonical NOP and must not write $0 path
            OP_RTYPE: begin
                ctrl_dec  = (i_if_id_instr == '0) ? 6'b000000 : 6'b100010;
                rt_is_src = 1'b1;
            end
            OP_J:    is_j = 1'b1;
            OP_BEQ:  begin is_beq = 1'b1; rt_is_src = 1'b1; end
            OP_BNE:  begin is_bne = 1'b1; rt_is_src = 1'b1; end
            OP_ADDI, OP_SLTI, OP_LUI: ctrl_dec = 6'b100001;
            OP_ANDI, OP_ORI: begin ctrl_dec = 6'b100001; zero_ext = 1'b1; end
            OP_LW:   ctrl_dec = 6'b110101;
            OP_SW:   begin ctrl_dec = 6'b001001; rt_is_src = 1'b1; end
            default: ctrl_dec = 6'b000000;
        endcase
    end

    logic signed [NB_BITS-1:0] imm_sext, br_off;
    logic        [NB_BITS-1:0] imm_ext;
    assign imm_sext = sext16(imm16);
    assign br_off   = imm_sext <<< 2;
    assign imm_ext  = zero_ext ? NB_BITS'(imm16) : $unsigned(imm_sext);

    assign o_brq_addr = i_if_id_pc + $unsigned(br_off);
    assign o_jmp_addr = {i_if_id_instr[NB_JMP-3:0], 2'b00};

    // Hazard detection
    logic [NB_REG-1:0] id_ex_dest;
    logic              load_use, br_hit_rs, br_hit_rt, br_hazard, stall, taken;

    assign id_ex_dest = id_ex_ctrl_q[1] ? id_ex_rd_q : id_ex_rt_q;

    assign load_use = id_ex_ctrl_q[4] && (id_ex_rt_q != '0) &&
                      ((id_ex_rt_q == rs) || (rt_is_src && id_ex_rt_q == rt));

    // A branch compares in ID, so any in-flight producer of its operands
    // (still in EX or in MEM) must drain to WB where the bypass can supply it.
    assign br_hit_rs = (rs != '0) &&
                       ((id_ex_ctrl_q[5] && id_ex_dest == rs) ||
                        (i_ex_mem_reg_write && i_ex_mem_rd == rs));
    assign br_hit_rt = (rt != '0) &&
                       ((id_ex_ctrl_q[5] && id_ex_dest == rt) ||
                        (i_ex_mem_reg_write && i_ex_mem_rd == rt));
    assign br_hazard = (is_beq || is_bne) && (br_hit_rs || br_hit_rt);

    assign stall = !i_rst && (load_use || br_hazard);
    assign taken = (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data);

    assign o_ctr_beq   = !i_rst && !stall && taken;
    assign o_ctr_jmp   = !i_rst && !stall && is_j;
    assign o_ctr_flush = o_ctr_beq || o_ctr_jmp;
    assign o_pc_we     = !stall;
    assign o_if_id_we  = !stall;

    assign id_ex_ctrl_d = stall ? 6'b000000 : ctrl_dec;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2**NB_REG; i++)
                regs_q[NB_REG'(i)] <= '0;
        end else if (i_wb_we && i_wb_addr != '0) begin
            regs_q[i_wb_addr] <= i_wb_data;
        end
    end

    // ---- ID / EX stage boundary ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_ex_pc_q      <= '0;
            id_ex_rs_data_q <= '0;
            id_ex_rt_data_q <= '0;
            id_ex_imm_q     <= '0;
            id_ex_rs_q      <= '0;
            id_ex_rt_q      <= '0;
            id_ex_rd_q      <= '0;
            id_ex_op_q      <= '0;
            id_ex_funct_q   <= '0;
            id_ex_ctrl_q    <= '0;
        end else begin
            id_ex_pc_q      <= i_if_id_pc;
            id_ex_rs_data_q <= rs_data;
            id_ex_rt_data_q <= rt_data;
            id_ex_imm_q     <= imm_ext;
            id_ex_rs_q      <= rs;
            id_ex_rt_q      <= rt;
            id_ex_rd_q      <= rd;
            id_ex_op_q      <= op;
            id_ex_funct_q   <= funct;
            id_ex_ctrl_q    <= id_ex_ctrl_d;
        end
    end

    assign o_id_ex_pc      = id_ex_pc_q;
    assign o_id_ex_rs_data = id_ex_rs_data_q;
    assign o_id_ex_rt_data = id_ex_rt_data_q;
    assign o_id_ex_imm     = id_ex_imm_q;
    assign o_id_ex_rs      = id_ex_rs_q;
    assign o_id_ex_rt      = id_ex_rt_q;
    assign o_id_ex_rd      = id_ex_rd_q;
    assign o_id_ex_op      = id_ex_op_q;
    assign o_id_ex_funct   = id_ex_funct_q;
    assign o_id_ex_ctrl    = id_ex_ctrl_q;

endmodule

// File: tb/tb_decode_module.sv
module tb_decode_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, instr, wb_data;
    logic        wb_we, exm_we;
    logic [4:0]  wb_addr, exm_rd;
    logic [31:0] brq, idex_pc, idex_rs_d, idex_rt_d, idex_imm;
    logic [25:0] jmp;
    logic        ctr_beq, ctr_jmp, ctr_flush, pc_we, ifid_we;
    logic [4:0]  idex_rs, idex_rt, idex_rd;
    logic [5:0]  idex_op, idex_funct, idex_ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_module dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_id_pc(pc), .i_if_id_instr(instr),
        .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_ex_mem_reg_write(exm_we), .i_ex_mem_rd(exm_rd),
        .o_brq_addr(brq), .o_jmp_addr(jmp),
        .o_ctr_beq(ctr_beq), .o_ctr_jmp(ctr_jmp), .o_ctr_flush(ctr_flush),
        .o_pc_we(pc_we), .o_if_id_we(ifid_we),
        .o_id_ex_pc(idex_pc), .o_id_ex_rs_data(idex_rs_d), .o_id_ex_rt_data(idex_rt_d),
        .o_id_ex_imm(idex_imm), .o_id_ex_rs(idex_rs), .o_id_ex_rt(idex_rt),
        .o_id_ex_rd(idex_rd), .o_id_ex_op(idex_op), .o_id_ex_funct(idex_funct),
        .o_id_ex_ctrl(idex_ctrl)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        beq, jmp, flush, chk_brq;
        logic [31:0] tgt;
        logic [5:0]  ctrl;
        logic [31:0] imm, rs_d, rt_d;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int stalls;
        //            instr         pc        beq  jmp  fl   brq  tgt       ctrl       imm           rs_d  rt_d
        tbl[0]  = '{32'h00222020, 32'h100, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100010, 32'h00002020, 32'd7, 32'd7};
        tbl[1]  = '{32'h30258001, 32'h104, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100001, 32'h00008001, 32'd7, 32'd0};
        tbl[2]  = '{32'h20258001, 32'h108, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100001, 32'hFFFF8001, 32'd7, 32'd0};
        tbl[3]  = '{32'h3446FFFF, 32'h10C, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100001, 32'h0000FFFF, 32'd7, 32'd0};
        tbl[4]  = '{32'h3C081234, 32'h110, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100001, 32'h00001234, 32'd0, 32'd0};
        tbl[5]  = '{32'h28E9FFFF, 32'h114, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b100001, 32'hFFFFFFFF, 32'd9, 32'd0};
        tbl[6]  = '{32'hAC270004, 32'h118, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b001001, 32'h00000004, 32'd7, 32'd9};
        tbl[7]  = '{32'hFC000000, 32'h11C, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b000000, 32'h00000000, 32'd0, 32'd0};
        tbl[8]  = '{32'h00000000, 32'h120, 1'b0,1'b0,1'b0,1'b0, 32'h0,  6'b000000, 32'h00000000, 32'd0, 32'd0};
        tbl[9]  = '{32'h10220003, 32'h020, 1'b1,1'b0,1'b1,1'b1, 32'h2C, 6'b000000, 32'h00000003, 32'd7, 32'd7};
        tbl[10] = '{32'h14220003, 32'h020, 1'b0,1'b0,1'b0,1'b1, 32'h2C, 6'b000000, 32'h00000003, 32'd7, 32'd7};
        tbl[11] = '{32'h08000010, 32'h024, 1'b0,1'b1,1'b1,1'b0, 32'h40, 6'b000000, 32'h00000010, 32'd0, 32'd0};
        tbl[12] = '{32'h1022FFFF, 32'h100, 1'b1,1'b0,1'b1,1'b1, 32'hFC, 6'b000000, 32'hFFFFFFFF, 32'd7, 32'd7};

        rst = 1'b1; pc = '0; instr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        exm_we = 1'b0; exm_rd = '0;
        tick(); tick();

        // Pre-write $5 and load a real instruction, then reset over it
        rst = 1'b0; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
        instr = 32'h00A02020; pc = 32'h40;
        tick();
        chk("prewrite_bypass_rs", idex_rs_d, 32'hAA);
        rst = 1'b1; wb_we = 1'b0; instr = 32'h10000001; pc = 32'h44;
        #1;
        chk("rst_pc_we", {31'd0, pc_we}, 32'd1);
        chk("rst_if_id_we", {31'd0, ifid_we}, 32'd1);
        chk("rst_beq", {31'd0, ctr_beq}, 32'd0);
        chk("rst_flush", {31'd0, ctr_flush}, 32'd0);
        tick();
        chk("rst_ctrl", {26'd0, idex_ctrl}, 32'd0);
        chk("rst_rs_data", idex_rs_d, 32'd0);
        chk("rst_pc", idex_pc, 32'd0);
        chk("rst_imm", idex_imm, 32'd0);
        chk("rst_op", {26'd0, idex_op}, 32'd0);
        rst = 1'b0; instr = 32'h00A02020; pc = 32'h48;
        tick();
        chk("post_rst_r5", idex_rs_d, 32'd0);
        chk("post_rst_ctrl", {26'd0, idex_ctrl}, 32'b100010);

        // Register setup: $1=7, $2=7, $7=9 with NOP in ID
        instr = '0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd7; tick();
        wb_addr = 5'd2; wb_data = 32'd7; tick();
        wb_addr = 5'd7; wb_data = 32'd9; tick();
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;

        for (int i = 0; i < 13; i++) begin
            instr = tbl[i].instr; pc = tbl[i].pc;
            #1;
            chk($sformatf("v%0d_beq", i), {31'd0, ctr_beq}, {31'd0, tbl[i].beq});
            chk($sformatf("v%0d_jmp", i), {31'd0, ctr_jmp}, {31'd0, tbl[i].jmp});
            chk($sformatf("v%0d_flush", i), {31'd0, ctr_flush}, {31'd0, tbl[i].flush});
            chk($sformatf("v%0d_pc_we", i), {31'd0, pc_we}, 32'd1);
            if (tbl[i].chk_brq) chk($sformatf("v%0d_brq", i), brq, tbl[i].tgt);
            if (tbl[i].jmp) chk($sformatf("v%0d_jaddr", i), {6'd0, jmp}, tbl[i].tgt);
            tick();
            chk($sformatf("v%0d_ctrl", i), {26'd0, idex_ctrl}, {26'd0, tbl[i].ctrl});
            chk($sformatf("v%0d_imm", i), idex_imm, tbl[i].imm);
            chk($sformatf("v%0d_rs_d", i), idex_rs_d, tbl[i].rs_d);
            chk($sformatf("v%0d_rt_d", i), idex_rt_d, tbl[i].rt_d);
            chk($sformatf("v%0d_pc", i), idex_pc, tbl[i].pc);
        end

        // WB bypass: $3=0x1234 written while add $4,$3,$0 is in ID
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h1234;
        instr = 32'h00602020; pc = 32'h200;
        tick();
        wb_we = 1'b0;
        chk("bypass_rs_data", idex_rs_d, 32'h1234);
        chk("bypass_ctrl", {26'd0, idex_ctrl}, 32'b100010);

        // Load-use: lw $2,0($1) then add $5,$2,$2
        stalls = 0;
        instr = 32'h8C220000; pc = 32'h204;
        #1;
        if (!pc_we) stalls++;
        tick();
        chk("lw_ctrl", {26'd0, idex_ctrl}, 32'b110101);
        instr = 32'h00422820; pc = 32'h208;
        #1;
        chk("lu_if_id_we", {31'd0, ifid_we}, 32'd0);
        if (!pc_we) stalls++;
        tick();
        chk("lu_bubble_ctrl", {26'd0, idex_ctrl}, 32'd0);
        #1;
        if (!pc_we) stalls++;
        tick();
        chk("lu_stall_cycles", stalls, 32'd1);
        chk("lu_add_ctrl", {26'd0, idex_ctrl}, 32'b100010);
        chk("lu_add_idx", {17'd0, idex_rs, idex_rt, idex_rd}, {17'd0, 5'd2, 5'd2, 5'd5});

        // Branch hazard: addi $1,$0,5 then beq $1,$0,+2
        stalls = 0;
        instr = 32'h20010005; pc = 32'h300;
        tick();
        instr = 32'h10200002; pc = 32'h304;
        #1;
        if (!pc_we) stalls++;
        chk("bh1_beq", {31'd0, ctr_beq}, 32'd0);
        tick();
        exm_we = 1'b1; exm_rd = 5'd1;
        #1;
        if (!pc_we) stalls++;
        chk("bh2_flush", {31'd0, ctr_flush}, 32'd0);
        tick();
        exm_we = 1'b0; exm_rd = '0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        #1;
        if (!pc_we) stalls++;
        chk("bh3_stall_cycles", stalls, 32'd2);
        chk("bh3_beq", {31'd0, ctr_beq}, 32'd0);
        chk("bh3_flush", {31'd0, ctr_flush}, 32'd0);
        tick();
        wb_we = 1'b0;
        chk("bh3_rs_data", idex_rs_d, 32'd5);

        // Writes to $0 are ignored, including through the bypass
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        instr = 32'h00002020; pc = 32'h400;
        tick();
        chk("r0_bypass", idex_rs_d, 32'd0);
        wb_we = 1'b0; wb_data = '0;
        tick();
        chk("r0_read", idex_rs_d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_module.md
Name: decode_module

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage; consumes its IF/ID pc (already pc+4) and instruction.
- Holds the 32x32 register file and decodes control.
- Resolves branches/jumps in ID and returns redirect, flush and stall controls to fetch.
- Detects load-use and branch-operand hazards; registers the ID/EX pipeline state for execute.

Parameters:
NB_BITS, 32, datapath/instruction width
NB_JMP, 26, width of jump-address field returned to fetch
NB_REG, 5, register-index width (2^NB_REG registers)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-high reset
i_if_id_pc  in  NB_BITS  IF/ID pc (address of instruction + 4)
i_if_id_instr  in  NB_BITS  IF/ID instruction
i_wb_we  in  1  writeback register-write enable
i_wb_addr  in  NB_REG  writeback destination register
i_wb_data  in  NB_BITS  writeback data
i_ex_mem_reg_write  in  1  EX/MEM instruction writes a register
i_ex_mem_rd  in  NB_REG  EX/MEM destination register
o_brq_addr  out  NB_BITS  branch target = i_if_id_pc + (sext(imm16)<<2)
o_jmp_addr  out  NB_JMP  {instr[23:0],2'b00}
o_ctr_beq  out  1  taken branch redirect
o_ctr_jmp  out  1  jump redirect
o_ctr_flush  out  1  replace next IF/ID instruction with NOP
o_pc_we  out  1  PC write enable (0 = stall)
o_if_id_we  out  1  IF/ID write enable (0 = stall)
o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm  out  NB_BITS each  registered pc, operands, sign/zero-extended imm
o_id_ex_rs, o_id_ex_rt, o_id_ex_rd  out  NB_REG each  registered register indices
o_id_ex_op, o_id_ex_funct  out  6 each  registered opcode/funct for ALU control
o_id_ex_ctrl  out  6  registered {reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src}

Behaviour:
- Reset (i_rst=1 at edge): all register-file entries and all ID/EX registers → 0. While i_rst=1: o_pc_we=1, o_if_id_we=1, o_ctr_beq=0, o_ctr_jmp=0, o_ctr_flush=0.
- Supported opcodes: R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B.
- Immediate extension: andi/ori zero-extend imm16; all other opcodes sign-extend.
- Unknown opcodes decode as NOP (ctrl=0).
- Register file:
  - Write on clock edge when i_wb_we=1 and i_wb_addr≠0; $0 always reads 0.
  - Combinational read with write-through bypass: a read of i_wb_addr in the same cycle as its write returns i_wb_data.
- Load-use hazard: asserted when ID/EX ctrl.mem_read=1, o_id_ex_rt≠0, and o_id_ex_rt equals rs, or equals rt when rt is a source.
  - Response: o_pc_we=0, o_if_id_we=0, next ID/EX ctrl=0 (bubble).
- Branch hazard (beq/bne in ID): asserted when rs or rt (≠0) matches either of these producers:
  - ID/EX rd-dest (rt if reg_dst=0) with reg_write=1;
  - i_ex_mem_rd with i_ex_mem_reg_write=1.
  - Response: same stall as load-use. No branch decision while stalled.
- Branch/jump resolution (only when not stalled):
  - beq with rs==rt, or bne with rs≠rt → o_ctr_beq=1, o_ctr_flush=1.
  - j → o_ctr_jmp=1, o_ctr_flush=1.
  - Outputs are combinational in the same cycle the instruction is in ID; the instruction itself proceeds to ID/EX with ctrl=0.
- Precedence: reset > stall > redirect. A stall suppresses beq/jmp/flush.
- ID/EX register: loads every cycle when not in reset; loads bubble (ctrl=0, other fields don't-care but deterministic) on stall. One-cycle latency ID→EX.
- An instruction word of all zeros (sll $0,$0,0) must produce ctrl=0.

Test Plan:
- Reset with register file pre-written → all o_id_ex_* = 0, o_pc_we=1, o_if_id_we=1; a subsequent read of $5 returns 0.
- WB writes $3=0x1234 in the same cycle as "add $4,$3,$0" is in ID → next cycle o_id_ex_rs_data=0x1234, ctrl=100010 (reg_write, reg_dst).
- "lw $2,0($1)" followed by "add $5,$2,$2" → exactly one cycle with o_pc_we=0, o_if_id_we=0 and bubble (ctrl=0); the add then issues with correct indices.
- With $1=$2=7: "beq $1,$2,+3" at i_if_id_pc=0x20 → o_ctr_beq=1, o_ctr_flush=1, o_brq_addr=0x2C. Same with "bne" → o_ctr_beq=0, o_ctr_flush=0.
- "addi $1,$0,5" directly before "beq $1,$0,x" → 2 stall cycles (ID/EX, then EX/MEM match); branch resolves in the third cycle with WB bypass.
- "j 0x0000010" → o_ctr_jmp=1, o_jmp_addr=0x40, o_ctr_flush=1; "$0" write attempt with i_wb_addr=0 leaves $0 reading 0.
